// File: rtl/count_mod10_checker.sv
// count_mod10_checker
// Passive in-line checker for a mod-10 up/down loadable counter. It samples
// the counter's stimulus (data_in, mode, load) and response (data_out) on
// every rising edge, runs its own reference model and reports disagreements.
//
// Handshake: there is none. Every input is a level sampled on each rising
// edge of clock, and every output is registered. A stimulus sampled at edge k
// sets exp_out for edge k+1, and the pulses from the compare at edge k+1 are
// visible directly after that edge.
//
// Operating phases (state_o):
//   IDLE  (00) adopt data_out as the model base, no compares
//   SYNC  (01) one more adopt cycle, no compares
//   CHECK (10) compare data_out against exp_out on every edge
// Dropping chk_en returns the checker to IDLE. An illegal load (data_in > 9)
// sends it to SYNC so the model re-adopts whatever the counter produced.
module count_mod10_checker #(
   parameter int ERR_W         = 8,
   parameter int CHK_W         = 16,
   parameter bit RESYNC_ON_ERR = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             chk_en,
   input  logic [3:0]       data_in,
   input  logic             mode,
   input  logic             load,
   input  logic [3:0]       data_out,
   output logic [3:0]       exp_out,
   output logic             mismatch,
   output logic             range_err,
   output logic             load_err,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_count,
   output logic [CHK_W-1:0] chk_count,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SYNC  = 2'b01,
      ST_CHECK = 2'b10
   } state_t;

   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   localparam logic [CHK_W-1:0] CHK_MAX = '1;

   state_t           state_q, state_d;
   logic [3:0]       exp_q, exp_d;
   logic             mismatch_q, mismatch_d;
   logic             range_err_q, range_err_d;
   logic             load_err_q, load_err_d;
   logic             sticky_q, sticky_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [CHK_W-1:0] chk_count_q, chk_count_d;

   logic             illegal_load;
   logic             out_of_range;
   logic             cmp_fail;
   logic [3:0]       base;

   // Next counter value from base v; load wins over the count direction.
   function automatic logic [3:0] next_val(input logic [3:0] v,
                                           input logic [3:0] din,
                                           input logic       up,
                                           input logic       ld);
      logic [3:0] r;
      if (ld) begin
         r = din;
      end else if (up) begin
         r = (v == 4'd9) ? 4'd0 : v + 4'd1;
      end else begin
         r = (v == 4'd0) ? 4'd9 : v - 4'd1;
      end
      return r;
   endfunction

   // Next-state, model and statistics computation for the coming edge.
   always_comb begin
      state_d      = state_q;
      exp_d        = exp_q;
      mismatch_d   = 1'b0;
      range_err_d  = 1'b0;
      load_err_d   = 1'b0;
      sticky_d     = sticky_q;
      err_count_d  = err_count_q;
      chk_count_d  = chk_count_q;
      base         = data_out;

      illegal_load = load && (data_in > 4'd9);
      out_of_range = data_out > 4'd9;
      // An out-of-range value is always a compare failure, even if the model
      // had itself drifted to the same illegal value.
      cmp_fail     = out_of_range || (data_out != exp_q);

      if (!chk_en) begin
         state_d = ST_IDLE;
         exp_d   = next_val(data_out, data_in, mode, load);
      end else begin
         range_err_d = out_of_range;
         load_err_d  = illegal_load;
         case (state_q)
            ST_IDLE: begin
               exp_d   = next_val(data_out, data_in, mode, load);
               state_d = ST_SYNC;
            end
            ST_SYNC: begin
               exp_d   = next_val(data_out, data_in, mode, load);
               state_d = ST_CHECK;
            end
            ST_CHECK: begin
               mismatch_d = cmp_fail;
               if (chk_count_q != CHK_MAX) begin
                  chk_count_d = chk_count_q + CHK_W'(1);
               end
               // One increment per failing edge, even with range_err also set.
               if (cmp_fail && (err_count_q != ERR_MAX)) begin
                  err_count_d = err_count_q + ERR_W'(1);
               end
               base    = (cmp_fail && RESYNC_ON_ERR) ? data_out : exp_q;
               exp_d   = next_val(base, data_in, mode, load);
               state_d = ST_CHECK;
            end
            default: begin
               exp_d   = next_val(data_out, data_in, mode, load);
               state_d = ST_IDLE;
            end
         endcase
         // The counter's response to an illegal load is undefined, so the
         // prediction from this edge is discarded by re-adopting in SYNC.
         if (illegal_load) begin
            state_d = ST_SYNC;
         end
         sticky_d = sticky_q | range_err_d | load_err_d | mismatch_d;
      end
   end

   // All checker state and outputs registered; reset clears everything.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         exp_q       <= 4'd0;
         mismatch_q  <= 1'b0;
         range_err_q <= 1'b0;
         load_err_q  <= 1'b0;
         sticky_q    <= 1'b0;
         err_count_q <= '0;
         chk_count_q <= '0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         mismatch_q  <= mismatch_d;
         range_err_q <= range_err_d;
         load_err_q  <= load_err_d;
         sticky_q    <= sticky_d;
         err_count_q <= err_count_d;
         chk_count_q <= chk_count_d;
      end
   end

   assign exp_out    = exp_q;
   assign mismatch   = mismatch_q;
   assign range_err  = range_err_q;
   assign load_err   = load_err_q;
   assign err_sticky = sticky_q;
   assign err_count  = err_count_q;
   assign chk_count  = chk_count_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_count_mod10_checker.sv
// Bench for count_mod10_checker: drives a behavioural mod-10 counter (with
// optional glitches) into the checker and compares every output against an
// independent model of the checker's reporting rules.
module tb_count_mod10_checker;

   localparam int ERR_W  = 8;
   localparam int CHK_W  = 16;
   localparam bit RESYNC = 1'b1;
   localparam int VW     = 4 + 4 + ERR_W + CHK_W + 2;

   logic             clock = 1'b0;
   logic             reset;
   logic             chk_en;
   logic [3:0]       data_in;
   logic             mode;
   logic             load;
   logic [3:0]       data_out;
   logic [3:0]       exp_out;
   logic             mismatch;
   logic             range_err;
   logic             load_err;
   logic             err_sticky;
   logic [ERR_W-1:0] err_count;
   logic [CHK_W-1:0] chk_count;
   logic [1:0]       state_o;

   count_mod10_checker #(
      .ERR_W(ERR_W), .CHK_W(CHK_W), .RESYNC_ON_ERR(RESYNC)
   ) dut (
      .clock(clock), .reset(reset), .chk_en(chk_en), .data_in(data_in),
      .mode(mode), .load(load), .data_out(data_out), .exp_out(exp_out),
      .mismatch(mismatch), .range_err(range_err), .load_err(load_err),
      .err_sticky(err_sticky), .err_count(err_count), .chk_count(chk_count),
      .state_o(state_o)
   );

   // clock / reset
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // bench-side counter and checker reference model
   int cnt;
   int m_exp, m_warm, m_err, m_chk;
   bit m_mis, m_rng, m_lerr, m_sticky;
   int err_max = (1 << ERR_W) - 1;
   int chk_max = (1 << CHK_W) - 1;

   logic [VW-1:0] dut_vec;
   assign dut_vec = {exp_out, mismatch, range_err, load_err, err_sticky,
                     err_count, chk_count, state_o};

   // Counter rule on 4-bit values: load wins, up wraps 9->0, down wraps 0->9.
   function automatic int spec_next(int v, int din, bit up, bit ld);
      if (ld) return din;
      if (up) return (v == 9) ? 0 : (v + 1) % 16;
      return (v == 0) ? 9 : v - 1;
   endfunction

   // m_warm = number of adopt cycles still to go before compares start.
   function automatic logic [VW-1:0] model_vec();
      logic [1:0] st;
      st = (m_warm >= 2) ? 2'd0 : (m_warm == 1) ? 2'd1 : 2'd2;
      return {4'(m_exp), m_mis, m_rng, m_lerr, m_sticky,
              ERR_W'(m_err), CHK_W'(m_chk), st};
   endfunction

   task automatic model_reset();
      cnt = 0; m_exp = 0; m_warm = 2; m_err = 0; m_chk = 0;
      m_mis = 0; m_rng = 0; m_lerr = 0; m_sticky = 0;
   endtask

   // driver: one clock cycle of stimulus, with the model updated at the edge
   task automatic step(input bit en, input int din, input bit up, input bit ld,
                       input bit force_en, input int force_val);
      int dout, cbase;
      dout     = force_en ? force_val : cnt;
      chk_en   = en;
      data_in  = din[3:0];
      mode     = up;
      load     = ld;
      data_out = dout[3:0];
      @(posedge clock);
      m_mis = 0; m_rng = 0; m_lerr = 0;
      if (!en) begin
         m_exp  = spec_next(dout, din, up, ld);
         m_warm = 2;
      end else begin
         m_rng  = dout > 9;
         m_lerr = ld && (din > 9);
         if (m_warm > 0) begin
            m_exp  = spec_next(dout, din, up, ld);
            m_warm = m_warm - 1;
         end else begin
            m_mis = (dout != m_exp) || (dout > 9);
            if (m_chk < chk_max) m_chk++;
            if (m_mis && m_err < err_max) m_err++;
            m_exp = spec_next((m_mis && RESYNC) ? dout : m_exp, din, up, ld);
         end
         if (m_lerr) m_warm = 1;
         m_sticky = m_sticky | m_rng | m_lerr | m_mis;
      end
      // a legal glitch is adopted by the counter; an illegal one is bus noise
      cbase = (force_en && force_val <= 9) ? force_val : cnt;
      cnt   = (ld && din > 9) ? 0 : spec_next(cbase, din, up, ld);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; chk_en = 1'b0; load = 1'b0; mode = 1'b1;
      data_in = 4'd0; data_out = 4'd0;
      model_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== '0) begin
         errors++; $display("FAIL reset_outputs got %h want 0", dut_vec);
      end
      checks++;
      if (state_o !== 2'd0) begin
         errors++; $display("FAIL reset_state got %0d want 0", state_o);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_count_up();
      do_reset();
      for (int i = 0; i < 25; i++) begin
         step(1, 0, 1, 0, 0, 0);
         checks++;
         if (mismatch !== 1'b0) begin
            errors++; $display("FAIL up_mismatch cyc %0d got %b want 0", i, mismatch);
         end
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL up_vec cyc %0d got %h want %h", i, dut_vec, model_vec());
         end
      end
      checks++;
      if (err_count !== '0) begin
         errors++; $display("FAIL up_err_count got %0d want 0", err_count);
      end
      checks++;
      if (chk_count !== CHK_W'(23)) begin
         errors++; $display("FAIL up_chk_count got %0d want 23", chk_count);
      end
   endtask

   task automatic test_down_wrap();
      step(1, 0, 1, 1, 0, 0);
      checks++;
      if (exp_out !== 4'd0) begin
         errors++; $display("FAIL down_load got %0d want 0", exp_out);
      end
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (exp_out !== 4'd9 || mismatch !== 1'b0) begin
         errors++; $display("FAIL down_wrap got %0d/%b want 9/0", exp_out, mismatch);
      end
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (exp_out !== 4'd8 || mismatch !== 1'b0) begin
         errors++; $display("FAIL down_next got %0d/%b want 8/0", exp_out, mismatch);
      end
   endtask

   task automatic test_fault();
      int prev;
      step(1, 3, 1, 1, 0, 0);
      prev = int'(err_count);
      step(1, 0, 1, 0, 1, 5);
      checks++;
      if (mismatch !== 1'b1 || err_sticky !== 1'b1) begin
         errors++; $display("FAIL fault_pulse got %b/%b want 1/1", mismatch, err_sticky);
      end
      checks++;
      if (int'(err_count) !== prev + 1) begin
         errors++; $display("FAIL fault_count got %0d want %0d", err_count, prev + 1);
      end
      checks++;
      if (exp_out !== (RESYNC ? 4'd6 : 4'd4)) begin
         errors++; $display("FAIL fault_next got %0d want %0d", exp_out, RESYNC ? 6 : 4);
      end
      step(1, 0, 1, 0, 0, 0);
      checks++;
      if (mismatch !== (RESYNC ? 1'b0 : 1'b1)) begin
         errors++; $display("FAIL fault_after got %b want %b", mismatch, !RESYNC);
      end
   endtask

   task automatic test_load_err();
      step(1, 12, 1, 1, 0, 0);
      checks++;
      if (load_err !== 1'b1 || state_o !== 2'd1 || err_sticky !== 1'b1) begin
         errors++; $display("FAIL lerr_pulse got %b/%0d/%b want 1/1/1", load_err, state_o, err_sticky);
      end
      step(1, 0, 1, 0, 0, 0);
      checks++;
      if (mismatch !== 1'b0 || load_err !== 1'b0 || state_o !== 2'd2) begin
         errors++; $display("FAIL lerr_after got %b/%b/%0d want 0/0/2", mismatch, load_err, state_o);
      end
      step(1, 0, 1, 0, 0, 0);
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++; $display("FAIL lerr_vec got %h want %h", dut_vec, model_vec());
      end
   endtask

   task automatic test_range();
      int prev;
      prev = int'(err_count);
      step(1, 0, 1, 0, 1, 11);
      checks++;
      if (range_err !== 1'b1 || mismatch !== 1'b1) begin
         errors++; $display("FAIL range_pulse got %b/%b want 1/1", range_err, mismatch);
      end
      checks++;
      if (int'(err_count) !== prev + 1) begin
         errors++; $display("FAIL range_count got %0d want %0d", err_count, prev + 1);
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 4, 1, (i == 0), 0, 0);
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL range_vec cyc %0d got %h want %h", i, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_random();
      bit en, up, ld, fe;
      int din, fv;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         en  = ($urandom_range(0, 19) != 0);
         up  = $urandom_range(0, 1);
         ld  = ($urandom_range(0, 7) == 0);
         din = $urandom_range(0, 11);
         fe  = ($urandom_range(0, 15) == 0);
         fv  = $urandom_range(0, 15);
         step(en, din, up, ld, fe, fv);
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL rand_vec cyc %0d got %h want %h", i, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_err_saturation();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step(1, 0, 1, 0, 1, (m_exp + 1) % 10);
      end
      checks++;
      if (int'(err_count) !== err_max) begin
         errors++; $display("FAIL sat_err_count got %0d want %0d", err_count, err_max);
      end
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++; $display("FAIL sat_vec got %h want %h", dut_vec, model_vec());
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1, (m_exp + 1) % 10);
      checks++;
      if (err_count !== ERR_W'(3)) begin
         errors++; $display("FAIL mid_pre_count got %0d want 3", err_count);
      end
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== '0 || state_o !== 2'd0) begin
         errors++; $display("FAIL mid_reset got %h want 0", dut_vec);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; chk_en = 1'b0; data_in = 4'd0; mode = 1'b1;
      load = 1'b0; data_out = 4'd0;
      test_reset();
      test_count_up();
      test_down_wrap();
      test_fault();
      test_load_err();
      test_range();
      test_random();
      test_err_saturation();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
